// File: rtl/tuart_tx.sv
// tuart_tx: 8N1 UART transmitter with registered tx_o/rdy_o.
// Define TUART_XONXOFF_EN to let xon_i/xoff_i pause new frames; otherwise they are ignored.
module tuart_tx #(
  parameter int CLK_FREQ_HZ    = 100_000_000,
  parameter int BAUD           = 115_200,
  parameter int CYCLES_PER_BIT = CLK_FREQ_HZ / BAUD
) (
  input  logic       clk_i,
  input  logic       rst_in,
  input  logic [7:0] data_i,
  input  logic       stb_i,
  output logic       rdy_o,
  output logic       tx_o,
  input  logic       xon_i,
  input  logic       xoff_i
);
  localparam int CW = $clog2(CYCLES_PER_BIT);
  localparam logic [CW-1:0] BAUD_MAX = CW'(CYCLES_PER_BIT - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state_q, state_d;
  logic [7:0] sh_q, sh_d;
  logic [2:0] bit_q, bit_d;
  logic [CW-1:0] baud_q, baud_d;
  logic tx_q, tx_d, rdy_q, rdy_d, paused_q, paused_d;
  logic baud_end, accept;
`ifdef TUART_XONXOFF_EN
  assign paused_d = xon_i ? 1'b0 : xoff_i ? 1'b1 : paused_q;
`else
  logic unused_fc;
  assign unused_fc = xon_i ^ xoff_i;
  assign paused_d  = 1'b0;
`endif
  assign baud_end = baud_q == BAUD_MAX;
  // The edge that ends STOP may already accept the next byte, so frames run back-to-back.
  assign accept = stb_i && (rdy_q || (state_q == STOP && baud_end && !paused_q));
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    baud_d  = (state_q == IDLE || baud_end) ? '0 : baud_q + 1'b1;
    case (state_q)
      START: if (baud_end) begin
        state_d = DATA;
        tx_d    = sh_q[0];
      end
      DATA: if (baud_end) begin
        bit_d   = bit_q + 1'b1;
        sh_d    = sh_q >> 1;
        tx_d    = bit_q == 3'd7 ? 1'b1 : sh_q[1];
        state_d = bit_q == 3'd7 ? STOP : DATA;
      end
      STOP: if (baud_end) state_d = IDLE;
      default: ;
    endcase
    if (accept) begin
      state_d = START;
      sh_d    = data_i;
      bit_d   = '0;
      tx_d    = 1'b0;
    end
    rdy_d = state_d == IDLE && !paused_d;
  end
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state_q  <= IDLE;
      sh_q     <= '0;
      bit_q    <= '0;
      baud_q   <= '0;
      tx_q     <= 1'b1;
      rdy_q    <= 1'b1;
      paused_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sh_q     <= sh_d;
      bit_q    <= bit_d;
      baud_q   <= baud_d;
      tx_q     <= tx_d;
      rdy_q    <= rdy_d;
      paused_q <= paused_d;
    end
  end
  assign tx_o  = tx_q;
  assign rdy_o = rdy_q;
endmodule

// File: tb/tb_tuart_tx.sv
// tb_tuart_tx: cycle-by-cycle frame model plus literal line-pattern checks for tuart_tx.
module tb_tuart_tx;
  localparam int CPB = 4;
  logic clk_i = 1'b0, rst_in = 1'b0, stb_i = 1'b0, xon_i = 1'b0, xoff_i = 1'b0;
  logic [7:0] data_i = 8'h00;
  logic rdy_o, tx_o;
  int n_cmp = 0, n_err = 0;
  tuart_tx #(.CLK_FREQ_HZ(460_800), .BAUD(115_200)) dut (
    .clk_i(clk_i), .rst_in(rst_in), .data_i(data_i), .stb_i(stb_i),
    .rdy_o(rdy_o), .tx_o(tx_o), .xon_i(xon_i), .xoff_i(xoff_i)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic line_bit(input logic [7:0] d, input int idx);
    return idx == 0 ? 1'b0 : idx == 9 ? 1'b1 : d[idx-1];
  endfunction
  // Model: a frame occupies 10*CPB edges from its accept edge; elapsed/CPB picks the bit on the line.
  bit m_busy = 0, m_paused = 0, p_old;
  int m_el = 0;
  logic [7:0] m_data = 8'h00;
  always @(posedge clk_i) begin
    if (!rst_in) begin
      m_busy = 0;
      m_paused = 0;
    end else begin
      if (m_busy) m_el++;
      if (m_busy && m_el == 10 * CPB) m_busy = 0;
      p_old = m_paused;
`ifdef TUART_XONXOFF_EN
      m_paused = xon_i ? 1'b0 : xoff_i ? 1'b1 : m_paused;
`endif
      if (stb_i && !m_busy && !p_old) begin
        m_busy = 1;
        m_el = 0;
        m_data = data_i;
      end
    end
    #1;
    chk("model_tx", 32'(tx_o), 32'(m_busy ? line_bit(m_data, m_el / CPB) : 1'b1));
    chk("model_rdy", 32'(rdy_o), 32'(!m_busy && !m_paused));
  end
  task automatic send(input logic [7:0] d);
    @(negedge clk_i);
    data_i = d;
    stb_i = 1'b1;
    @(posedge clk_i);
    #1;
    stb_i = 1'b0;
    data_i = ~d;
  endtask
  task automatic grab(output logic [9:0] b);
    b = '0;
    for (int i = 0; i < 10 * CPB; i++) begin
      @(negedge clk_i);
      if (i % CPB == 1) b[i/CPB] = tx_o;
    end
  endtask
  initial begin
    #200_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [9:0] b;
    repeat (3) @(negedge clk_i);
    chk("reset_tx", 32'(tx_o), 32'd1);
    chk("reset_rdy", 32'(rdy_o), 32'd1);
    rst_in = 1'b1;
    repeat (2) @(negedge clk_i);
    send(8'h55);
    grab(b);
    chk("frame_55", 32'(b), 32'(10'b1010101010));
    @(posedge clk_i);
    #1;
    chk("rdy_after_55", 32'(rdy_o), 32'd1);
    send(8'hA3);
    grab(b);
    chk("frame_A3", 32'(b), 32'(10'b1101000110));
    data_i = 8'h0F;
    stb_i = 1'b1;
    @(posedge clk_i);
    #1;
    stb_i = 1'b0;
    chk("b2b_start", 32'(tx_o), 32'd0);
    grab(b);
    chk("frame_0F", 32'(b), 32'(10'b1000011110));
    @(posedge clk_i);
    #1;
    chk("rdy_after_0F", 32'(rdy_o), 32'd1);
    send(8'h00);
    fork
      grab(b);
      begin
        repeat (5) @(negedge clk_i);
        data_i = 8'hFF;
        stb_i = 1'b1;
        @(negedge clk_i);
        stb_i = 1'b0;
      end
    join
    chk("frame_00", 32'(b), 32'(10'b1000000000));
    repeat (3) @(negedge clk_i);
    chk("idle_after_00", 32'(tx_o), 32'd1);
`ifdef TUART_XONXOFF_EN
    send(8'h12);
    fork
      grab(b);
      begin
        repeat (10) @(negedge clk_i);
        xoff_i = 1'b1;
        @(negedge clk_i);
        xoff_i = 1'b0;
      end
    join
    chk("frame_12_paused", 32'(b), 32'(10'b1000100100));
    data_i = 8'h77;
    stb_i = 1'b1;
    repeat (100) @(negedge clk_i);
    chk("paused_rdy", 32'(rdy_o), 32'd0);
    chk("paused_tx", 32'(tx_o), 32'd1);
    stb_i = 1'b0;
    @(negedge clk_i);
    xon_i = 1'b1;
    @(posedge clk_i);
    #1;
    xon_i = 1'b0;
    chk("xon_rdy", 32'(rdy_o), 32'd1);
    send(8'h12);
    grab(b);
    chk("frame_12_resumed", 32'(b), 32'(10'b1000100100));
    @(negedge clk_i);
    xon_i = 1'b1;
    xoff_i = 1'b1;
    @(posedge clk_i);
    #1;
    xon_i = 1'b0;
    xoff_i = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("xon_wins_rdy", 32'(rdy_o), 32'd1);
`else
    @(negedge clk_i);
    xoff_i = 1'b1;
    @(negedge clk_i);
    xoff_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("xoff_ignored_rdy", 32'(rdy_o), 32'd1);
    send(8'h3C);
    grab(b);
    chk("frame_3C", 32'(b), 32'(10'b1001111000));
`endif
    send(8'h81);
    repeat (18) @(negedge clk_i);
    chk("bit3_before_reset", 32'(tx_o), 32'd0);
    #2;
    rst_in = 1'b0;
    #1;
    chk("async_reset_tx", 32'(tx_o), 32'd1);
    chk("async_reset_rdy", 32'(rdy_o), 32'd1);
    @(negedge clk_i);
    rst_in = 1'b1;
    send(8'h81);
    grab(b);
    chk("frame_81", 32'(b), 32'(10'b1100000010));
    @(posedge clk_i);
    #1;
    chk("rdy_after_81", 32'(rdy_o), 32'd1);
    repeat (3) @(negedge clk_i);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
